// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD-card SPI command engine: FSM encoding, frame
// fields, common command indices/CRCs and the command-frame byte selector.
package sd_spi_pkg;

  localparam logic [2:0] ST_INIT_CLK = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_SEND     = 3'd2;
  localparam logic [2:0] ST_POLL     = 3'd3;
  localparam logic [2:0] ST_READ_EXT = 3'd4;
  localparam logic [2:0] ST_TRAIL    = 3'd5;

  localparam logic [1:0] FRAME_START = 2'b01;
  localparam logic       FRAME_STOP  = 1'b1;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;

  localparam logic [5:0] CMD0     = 6'd0;
  localparam logic [6:0] CRC_CMD0 = 7'h4A;
  localparam logic [5:0] CMD8     = 6'd8;
  localparam logic [6:0] CRC_CMD8 = 7'h43;
  localparam logic [5:0] CMD55    = 6'd55;
  localparam logic [5:0] ACMD41   = 6'd41;
  localparam logic [5:0] CMD58    = 6'd58;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [2:0]  ext;
  } sd_cmd_t;

  // Byte n (0..5) of the 48-bit command frame, MSB first.
  function automatic logic [7:0] frame_byte(input sd_cmd_t c, input logic [2:0] n);
    case (n)
      3'd0:    frame_byte = {FRAME_START, c.idx};
      3'd1:    frame_byte = c.arg[31:24];
      3'd2:    frame_byte = c.arg[23:16];
      3'd3:    frame_byte = c.arg[15:8];
      3'd4:    frame_byte = c.arg[7:0];
      3'd5:    frame_byte = {c.crc, FRAME_STOP};
      default: frame_byte = IDLE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/sd_spi_byte_xfer.sv
// One full-duplex SPI mode-0 byte: SCLK divider, MOSI shift on falling edges,
// MISO capture in the cycle SCLK rises. Runs only while a byte is in flight.
module sd_spi_byte_xfer #(
  parameter int CLK_DIV = 125
) (
  input  logic       CLOCK50,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi
);
  localparam int DW = $clog2(CLK_DIV);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [3:0]    half_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          tick;

  assign tick    = active && (div_cnt == DW'(CLK_DIV - 1));
  assign mosi    = tx_sr[7];
  assign rx_byte = rx_sr;

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      tx_sr    <= 8'hFF;
      rx_sr    <= 8'hFF;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active   <= 1'b1;
          tx_sr    <= tx_byte;
          div_cnt  <= '0;
          half_cnt <= '0;
        end
      end else if (tick) begin
        div_cnt  <= '0;
        sclk     <= ~sclk;
        half_cnt <= half_cnt + 4'd1;
        // Ones refill the shifter so MOSI returns high after the last bit.
        if (!sclk) rx_sr <= {rx_sr[6:0], miso};
        else       tx_sr <= {tx_sr[6:0], 1'b1};
        if (half_cnt == 4'd15) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI command engine: power-up dummy clocks, then strobe-driven 48-bit
// command frames with R1 polling, optional extra response bytes and a trailer.
module sd_spi_cmd_engine #(
  parameter int CLK_DIV   = 125,
  parameter int INIT_CLKS = 80,
  parameter int NCR_MAX   = 16,
  parameter int MAX_EXT   = 4
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        CMD_STB,
  input  logic [5:0]  CMD_IDX,
  input  logic [31:0] CMD_ARG,
  input  logic [6:0]  CMD_CRC,
  input  logic [2:0]  CMD_EXT,
  output logic        CMD_BUSY,
  output logic        RESP_STB,
  output logic [7:0]  RESP_R1,
  output logic [31:0] RESP_EXT,
  output logic        RESP_TO,
  output logic        INIT_DONE,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS
);
  import sd_spi_pkg::*;

  localparam int INIT_BYTES = (INIT_CLKS + 7) / 8;
  localparam int IW = (INIT_BYTES > 1) ? $clog2(INIT_BYTES) : 1;
  localparam int PW = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
  localparam int EW = (MAX_EXT > 1) ? $clog2(MAX_EXT) : 1;
  localparam logic [2:0] EXT_LIMIT = 3'(MAX_EXT);

  logic [2:0]    state;
  sd_cmd_t       cmd_q;
  logic          init_go;
  logic [IW-1:0] init_cnt;
  logic [2:0]    send_cnt;
  logic [PW-1:0] poll_cnt;
  logic [EW-1:0] ext_cnt;
  logic          xfer_start;
  logic [7:0]    xfer_tx;
  logic          xfer_done;
  logic [7:0]    rx_byte;
  logic          accept;
  logic [2:0]    ext_sat;

  assign accept  = (state == ST_IDLE) && CMD_STB && INIT_DONE && !CMD_BUSY;
  assign ext_sat = (CMD_EXT > EXT_LIMIT) ? EXT_LIMIT : CMD_EXT;

  sd_spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .CLOCK50 (CLOCK50),
    .RESET   (RESET),
    .start   (xfer_start),
    .tx_byte (xfer_tx),
    .miso    (MISO),
    .rx_byte (rx_byte),
    .done    (xfer_done),
    .sclk    (SCLK),
    .mosi    (MOSI)
  );

  // Command fields are plain data, captured once per accepted command.
  always_ff @(posedge CLOCK50) begin
    if (accept) begin
      cmd_q.idx <= CMD_IDX;
      cmd_q.arg <= CMD_ARG;
      cmd_q.crc <= CMD_CRC;
      cmd_q.ext <= ext_sat;
    end
  end

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      state      <= ST_INIT_CLK;
      init_go    <= 1'b0;
      init_cnt   <= '0;
      send_cnt   <= '0;
      poll_cnt   <= '0;
      ext_cnt    <= '0;
      xfer_start <= 1'b0;
      xfer_tx    <= IDLE_BYTE;
      CS         <= 1'b1;
      CMD_BUSY   <= 1'b0;
      RESP_STB   <= 1'b0;
      RESP_R1    <= IDLE_BYTE;
      RESP_EXT   <= '0;
      RESP_TO    <= 1'b0;
      INIT_DONE  <= 1'b0;
    end else begin
      xfer_start <= 1'b0;
      RESP_STB   <= 1'b0;
      case (state)
        ST_INIT_CLK: begin
          if (!init_go) begin
            init_go    <= 1'b1;
            xfer_start <= 1'b1;
            xfer_tx    <= IDLE_BYTE;
          end else if (xfer_done) begin
            if (init_cnt == IW'(INIT_BYTES - 1)) begin
              INIT_DONE <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              init_cnt   <= init_cnt + 1'b1;
              xfer_start <= 1'b1;
            end
          end
        end

        ST_IDLE: begin
          // BUSY covers the RESP_STB cycle so a strobe there is not taken.
          if (RESP_STB) CMD_BUSY <= 1'b0;
          if (accept) begin
            CMD_BUSY   <= 1'b1;
            CS         <= 1'b0;
            RESP_R1    <= IDLE_BYTE;
            RESP_EXT   <= '0;
            RESP_TO    <= 1'b0;
            send_cnt   <= '0;
            xfer_start <= 1'b1;
            xfer_tx    <= {FRAME_START, CMD_IDX};
            state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (xfer_done) begin
            xfer_start <= 1'b1;
            if (send_cnt == 3'd5) begin
              xfer_tx  <= IDLE_BYTE;
              poll_cnt <= '0;
              state    <= ST_POLL;
            end else begin
              send_cnt <= send_cnt + 3'd1;
              xfer_tx  <= frame_byte(cmd_q, send_cnt + 3'd1);
            end
          end
        end

        ST_POLL: begin
          if (xfer_done) begin
            xfer_start <= 1'b1;
            xfer_tx    <= IDLE_BYTE;
            if (!rx_byte[7]) begin
              RESP_R1 <= rx_byte;
              if (cmd_q.ext != 3'd0) begin
                ext_cnt <= '0;
                state   <= ST_READ_EXT;
              end else begin
                CS    <= 1'b1;
                state <= ST_TRAIL;
              end
            end else if (poll_cnt == PW'(NCR_MAX - 1)) begin
              RESP_TO <= 1'b1;
              RESP_R1 <= IDLE_BYTE;
              CS      <= 1'b1;
              state   <= ST_TRAIL;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end

        ST_READ_EXT: begin
          if (xfer_done) begin
            xfer_start <= 1'b1;
            xfer_tx    <= IDLE_BYTE;
            RESP_EXT   <= {RESP_EXT[23:0], rx_byte};
            if (ext_cnt == EW'(cmd_q.ext - 3'd1)) begin
              CS    <= 1'b1;
              state <= ST_TRAIL;
            end else begin
              ext_cnt <= ext_cnt + 1'b1;
            end
          end
        end

        ST_TRAIL: begin
          if (xfer_done) begin
            RESP_STB <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine with a byte-list SD card model on MISO
// and a MOSI byte recorder keyed to SCLK rising edges.
module tb_sd_spi_cmd_engine;

  logic        CLOCK50 = 1'b0;
  logic        RESET   = 1'b1;
  logic        CMD_STB = 1'b0;
  logic [5:0]  CMD_IDX = '0;
  logic [31:0] CMD_ARG = '0;
  logic [6:0]  CMD_CRC = '0;
  logic [2:0]  CMD_EXT = '0;
  logic        CMD_BUSY, RESP_STB, RESP_TO, INIT_DONE, SCLK, MOSI, CS;
  logic [7:0]  RESP_R1;
  logic [31:0] RESP_EXT;
  logic        MISO;

  int n_tests = 0;
  int n_fail  = 0;

  sd_spi_cmd_engine #(.CLK_DIV(2), .INIT_CLKS(80), .NCR_MAX(16), .MAX_EXT(4)) dut (
    .CLOCK50(CLOCK50), .RESET(RESET), .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX),
    .CMD_ARG(CMD_ARG), .CMD_CRC(CMD_CRC), .CMD_EXT(CMD_EXT), .CMD_BUSY(CMD_BUSY),
    .RESP_STB(RESP_STB), .RESP_R1(RESP_R1), .RESP_EXT(RESP_EXT), .RESP_TO(RESP_TO),
    .INIT_DONE(INIT_DONE), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
  );

  always #5 CLOCK50 = ~CLOCK50;

  // Card model: byte list shifted out MSB first while CS is low, 1s otherwise.
  logic [7:0] card_bytes [0:31];
  int         card_len = 0;
  int         fall_cnt = 0;
  logic       sclk_q = 1'b0;
  logic [7:0] cb;
  logic [2:0] bi;

  always_comb begin
    MISO = 1'b1;
    cb   = 8'hFF;
    bi   = 3'(fall_cnt % 8);
    if (!CS && fall_cnt < card_len * 8) begin
      cb   = card_bytes[5'(fall_cnt / 8)];
      MISO = cb[3'd7 - bi];
    end
  end

  // Recorder, sampled on the falling CLOCK50 edge.
  logic [7:0] mo_bytes [$];
  logic       mo_cs [$];
  logic [7:0] mo_sr = 8'h00;
  int         mo_n = 0;
  int         rise_total = 0;
  int         init_rises = 0;
  int         init_bad = 0;
  int         stb_cnt = 0;

  always @(negedge CLOCK50) begin
    sclk_q <= SCLK;
    if (CS) fall_cnt <= 0;
    else if (sclk_q && !SCLK) fall_cnt <= fall_cnt + 1;
    if (RESP_STB) stb_cnt <= stb_cnt + 1;
    if (RESET) begin
      mo_n       <= 0;
      init_rises <= 0;
      init_bad   <= 0;
    end else if (!sclk_q && SCLK) begin
      rise_total <= rise_total + 1;
      if (!INIT_DONE) begin
        init_rises <= init_rises + 1;
        if (!CS || !MOSI) init_bad <= init_bad + 1;
      end
      mo_sr <= {mo_sr[6:0], MOSI};
      if (mo_n == 7) begin
        mo_bytes.push_back({mo_sr[6:0], MOSI});
        mo_cs.push_back(CS);
        mo_n <= 0;
      end else begin
        mo_n <= mo_n + 1;
      end
    end
  end

  int mo_base  = 0;
  int stb_base = 0;

  task automatic card_prefix();
    for (int i = 0; i < 32; i++) card_bytes[i] = 8'hFF;
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                        input logic [2:0] ext, input int mid, input bit poke_resp, output bit got);
    mo_base  = mo_bytes.size();
    stb_base = stb_cnt;
    @(negedge CLOCK50);
    CMD_IDX = idx; CMD_ARG = arg; CMD_CRC = crc; CMD_EXT = ext; CMD_STB = 1'b1;
    @(negedge CLOCK50);
    CMD_STB = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK50);
      if (mid > 0 && i == mid) begin
        CMD_IDX = 6'h11; CMD_ARG = 32'hDEADBEEF; CMD_CRC = 7'h00; CMD_STB = 1'b1;
      end
      if (mid > 0 && i == mid + 1) CMD_STB = 1'b0;
      if (RESP_STB) begin
        got = 1'b1;
        if (poke_resp) begin
          CMD_IDX = 6'h22; CMD_ARG = 32'hCAFEF00D; CMD_STB = 1'b1;
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK50);
    n_tests++;
    if ({SCLK, MOSI, CS, CMD_BUSY, RESP_STB, RESP_TO, INIT_DONE} !== 7'b0110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0110000",
               {SCLK, MOSI, CS, CMD_BUSY, RESP_STB, RESP_TO, INIT_DONE});
    end
    n_tests++;
    if (RESP_R1 !== 8'hFF) begin n_fail++; $display("FAIL reset_r1: got %h want ff", RESP_R1); end
    n_tests++;
    if (RESP_EXT !== 32'h0) begin n_fail++; $display("FAIL reset_ext: got %h want 0", RESP_EXT); end
  endtask

  task automatic test_init(input string tag);
    int cyc = 0;
    bit ok = 1'b0;
    int r0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK50);
      cyc++;
      if (i == 40) CMD_STB = 1'b1;
      if (i == 41) CMD_STB = 1'b0;
      if (INIT_DONE) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_done: INIT_DONE never rose", tag); end
    n_tests++;
    if (cyc < 320 || cyc > 360) begin
      n_fail++; $display("FAIL %s_cycles: got %0d want 320..360", tag, cyc);
    end
    n_tests++;
    if (init_rises != 80) begin
      n_fail++; $display("FAIL %s_rises: got %0d want 80", tag, init_rises);
    end
    n_tests++;
    if (init_bad != 0) begin
      n_fail++; $display("FAIL %s_cs_mosi: got %0d bad edges want 0", tag, init_bad);
    end
    r0 = rise_total;
    repeat (50) @(negedge CLOCK50);
    n_tests++;
    if (rise_total != r0) begin
      n_fail++; $display("FAIL %s_idle_sclk: got %0d edges want 0", tag, rise_total - r0);
    end
    n_tests++;
    if ({CMD_BUSY, CS, SCLK, MOSI} !== 4'b0101) begin
      n_fail++; $display("FAIL %s_stb_ignored: got %b want 0101", tag, {CMD_BUSY, CS, SCLK, MOSI});
    end
  endtask

  task automatic test_cmd0();
    logic [7:0] exp [0:9] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] b;
    bit got;
    card_prefix();
    card_bytes[8] = 8'h01;
    card_len = 9;
    do_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 0, 1'b0, got);
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL cmd0_stb: got none want RESP_STB"); end
    n_tests++;
    if ({RESP_R1, RESP_TO} !== {8'h01, 1'b0}) begin
      n_fail++; $display("FAIL cmd0_resp: got r1=%h to=%b want r1=01 to=0", RESP_R1, RESP_TO);
    end
    repeat (4) @(negedge CLOCK50);
    n_tests++;
    if (stb_cnt != stb_base + 1) begin
      n_fail++; $display("FAIL cmd0_pulses: got %0d want 1", stb_cnt - stb_base);
    end
    n_tests++;
    if (mo_bytes.size() != mo_base + 10) begin
      n_fail++; $display("FAIL cmd0_nbytes: got %0d want 10", mo_bytes.size() - mo_base);
    end
    for (int i = 0; i < 10; i++) begin
      b = (mo_base + i < mo_bytes.size()) ? mo_bytes[mo_base + i] : 8'hxx;
      n_tests++;
      if (b !== exp[i]) begin n_fail++; $display("FAIL cmd0_mosi[%0d]: got %h want %h", i, b, exp[i]); end
    end
    n_tests++;
    if (mo_bytes.size() >= mo_base + 10 && {mo_cs[mo_base + 8], mo_cs[mo_base + 9]} !== 2'b01) begin
      n_fail++; $display("FAIL cmd0_trail_cs: got %b want 01", {mo_cs[mo_base + 8], mo_cs[mo_base + 9]});
    end
    n_tests++;
    if ({CMD_BUSY, CS} !== 2'b01) begin
      n_fail++; $display("FAIL cmd0_idle: got busy/cs %b want 01", {CMD_BUSY, CS});
    end
  endtask

  task automatic test_cmd8();
    logic [7:0] exp [0:5] = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    logic [7:0] b;
    bit got;
    card_prefix();
    card_bytes[6] = 8'h01; card_bytes[7] = 8'h00; card_bytes[8] = 8'h00;
    card_bytes[9] = 8'h01; card_bytes[10] = 8'hAA;
    card_len = 11;
    do_cmd(6'd8, 32'h000001AA, 7'h43, 3'd4, 0, 1'b0, got);
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL cmd8_stb: got none want RESP_STB"); end
    n_tests++;
    if ({RESP_R1, RESP_EXT, RESP_TO} !== {8'h01, 32'h000001AA, 1'b0}) begin
      n_fail++; $display("FAIL cmd8_resp: got r1=%h ext=%h to=%b want 01 000001aa 0", RESP_R1, RESP_EXT, RESP_TO);
    end
    repeat (20) @(negedge CLOCK50);
    n_tests++;
    if ({RESP_R1, RESP_EXT} !== {8'h01, 32'h000001AA}) begin
      n_fail++; $display("FAIL cmd8_hold: got r1=%h ext=%h want 01 000001aa", RESP_R1, RESP_EXT);
    end
    n_tests++;
    if (mo_bytes.size() != mo_base + 12) begin
      n_fail++; $display("FAIL cmd8_nbytes: got %0d want 12", mo_bytes.size() - mo_base);
    end
    for (int i = 0; i < 6; i++) begin
      b = (mo_base + i < mo_bytes.size()) ? mo_bytes[mo_base + i] : 8'hxx;
      n_tests++;
      if (b !== exp[i]) begin n_fail++; $display("FAIL cmd8_mosi[%0d]: got %h want %h", i, b, exp[i]); end
    end
  endtask

  task automatic test_ext_saturate();
    bit got;
    card_prefix();
    card_bytes[6] = 8'h05; card_bytes[7] = 8'h11; card_bytes[8] = 8'h22;
    card_bytes[9] = 8'h33; card_bytes[10] = 8'h44; card_bytes[11] = 8'h55;
    card_len = 12;
    do_cmd(6'd58, 32'h0, 7'h7E, 3'd7, 0, 1'b0, got);
    n_tests++;
    if ({got, RESP_R1, RESP_EXT} !== {1'b1, 8'h05, 32'h11223344}) begin
      n_fail++; $display("FAIL ext_sat: got stb=%b r1=%h ext=%h want 1 05 11223344", got, RESP_R1, RESP_EXT);
    end
    repeat (4) @(negedge CLOCK50);
    n_tests++;
    if (mo_bytes.size() != mo_base + 12) begin
      n_fail++; $display("FAIL ext_sat_nbytes: got %0d want 12", mo_bytes.size() - mo_base);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    bit got;
    int bad = 0;
    card_len = 0;
    do_cmd(6'd41, 32'h40000000, 7'h3B, 3'd2, 0, 1'b0, got);
    n_tests++;
    if ({got, RESP_TO, RESP_R1, RESP_EXT} !== {1'b1, 1'b1, 8'hFF, 32'h0}) begin
      n_fail++; $display("FAIL timeout_resp: got stb=%b to=%b r1=%h ext=%h want 1 1 ff 0", got, RESP_TO, RESP_R1, RESP_EXT);
    end
    repeat (4) @(negedge CLOCK50);
    n_tests++;
    if (mo_bytes.size() != mo_base + 23) begin
      n_fail++; $display("FAIL timeout_nbytes: got %0d want 23", mo_bytes.size() - mo_base);
    end
    for (int i = 6; i < 22; i++) begin
      b = (mo_base + i < mo_bytes.size()) ? mo_bytes[mo_base + i] : 8'hxx;
      if (b !== 8'hFF || mo_cs[mo_base + i] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL timeout_polls: got %0d bad poll bytes want 0", bad); end
    b = (mo_base + 22 < mo_bytes.size()) ? mo_bytes[mo_base + 22] : 8'hxx;
    n_tests++;
    if (b !== 8'hFF || mo_cs[mo_base + 22] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_trail: got %h want ff with CS high", b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [0:7] = '{8'h77, 8'h12, 8'h34, 8'h56, 8'h78, 8'h65, 8'hFF, 8'hFF};
    logic [7:0] b;
    bit got;
    card_prefix();
    card_bytes[6] = 8'h00;
    card_len = 7;
    do_cmd(6'd55, 32'h12345678, 7'h32, 3'd0, 60, 1'b1, got);
    @(negedge CLOCK50);
    CMD_STB = 1'b0;
    n_tests++;
    if ({got, RESP_R1, RESP_TO} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL busy_resp: got stb=%b r1=%h to=%b want 1 00 0", got, RESP_R1, RESP_TO);
    end
    repeat (10) @(negedge CLOCK50);
    n_tests++;
    if ({CMD_BUSY, CS} !== 2'b01) begin
      n_fail++; $display("FAIL stb_at_resp: got busy/cs %b want 01", {CMD_BUSY, CS});
    end
    n_tests++;
    if (mo_bytes.size() != mo_base + 8) begin
      n_fail++; $display("FAIL busy_nbytes: got %0d want 8", mo_bytes.size() - mo_base);
    end
    for (int i = 0; i < 8; i++) begin
      b = (mo_base + i < mo_bytes.size()) ? mo_bytes[mo_base + i] : 8'hxx;
      n_tests++;
      if (b !== exp[i]) begin n_fail++; $display("FAIL busy_mosi[%0d]: got %h want %h", i, b, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_send();
    bit reached = 1'b0;
    card_len = 0;
    mo_base  = mo_bytes.size();
    stb_base = stb_cnt;
    @(negedge CLOCK50);
    CMD_IDX = 6'd0; CMD_ARG = 32'hA5A5A5A5; CMD_CRC = 7'h4A; CMD_EXT = 3'd0; CMD_STB = 1'b1;
    @(negedge CLOCK50);
    CMD_STB = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLOCK50);
      if (mo_bytes.size() >= mo_base + 2) begin reached = 1'b1; break; end
    end
    n_tests++;
    if (!reached) begin n_fail++; $display("FAIL rst_mid_reach: byte 2 never started"); end
    repeat (8) @(negedge CLOCK50);
    RESET = 1'b1;
    #1;
    n_tests++;
    if ({CS, SCLK, MOSI, CMD_BUSY, INIT_DONE, RESP_STB} !== 6'b101000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b want 101000", {CS, SCLK, MOSI, CMD_BUSY, INIT_DONE, RESP_STB});
    end
    repeat (3) @(negedge CLOCK50);
    RESET = 1'b0;
    test_init("reinit");
    n_tests++;
    if (stb_cnt != stb_base) begin
      n_fail++; $display("FAIL rst_mid_no_stb: got %0d pulses want 0", stb_cnt - stb_base);
    end
  endtask

  initial begin
    test_reset();
    @(negedge CLOCK50);
    RESET = 1'b0;
    test_init("init");
    test_cmd0();
    test_cmd8();
    test_ext_saturate();
    test_timeout();
    test_back_to_back();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
